// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register-file read port through R0..R(NREG-1)
// and streams {index, data} words over valid/ready. Define REGDUMP_CKSUM_EN to append an XOR checksum word.
module regfile_dump #(
  parameter int unsigned NREG   = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] SR_ADDR,
  input  logic [15:0]       SR_DATA,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [ADDR_W:0]   out_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

`ifdef REGDUMP_CKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CKSUM, S_DONE} state_t;
  localparam logic [ADDR_W:0] CKSUM_IDX = (ADDR_W+1)'(NREG);
  logic [DATA_W-1:0] acc;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] rd_idx;

  // Read address comes straight from a register so it is settled a full cycle before capture.
  assign SR_ADDR = rd_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGDUMP_CKSUM_EN
      acc       <= '0;
`endif
    end else if (state != S_IDLE && abort) begin
      state     <= S_IDLE;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGDUMP_CKSUM_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_idx <= '0;
            busy   <= 1'b1;
            state  <= S_READ;
`ifdef REGDUMP_CKSUM_EN
            acc    <= '0;
`endif
          end
        end
        S_READ: begin
          out_data  <= SR_DATA;
          out_idx   <= {1'b0, rd_idx};
          out_valid <= 1'b1;
          state     <= S_SEND;
`ifdef REGDUMP_CKSUM_EN
          acc       <= acc ^ SR_DATA;
`endif
        end
        S_SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (rd_idx == LAST_IDX) begin
`ifdef REGDUMP_CKSUM_EN
              // Accumulator already holds every captured value here.
              out_valid <= 1'b1;
              out_data  <= acc;
              out_idx   <= CKSUM_IDX;
              state     <= S_CKSUM;
`else
              done      <= 1'b1;
              state     <= S_DONE;
`endif
            end else begin
              rd_idx <= rd_idx + ADDR_W'(1);
              state  <= S_READ;
            end
          end
        end
`ifdef REGDUMP_CKSUM_EN
        S_CKSUM: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
